// File: rtl/branch_predictor.sv
//==============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with per-entry 2-bit
//               saturating counters. Lookup is purely combinational (same-cycle
//               prediction); updates from the resolve stage are written on the
//               rising clock edge with no bypass into the lookup path.
//               Also keeps a saturating 16-bit misprediction counter.
// Ports       : Clk, Reset            - clock, synchronous active-high reset
//               lookup_pc             - PC of the instruction being fetched
//               pred_taken            - taken prediction for lookup_pc
//               pred_next_pc          - predicted next fetch address
//               upd_valid/pc/taken/   - resolved branch information
//               upd_target/upd_pred_taken
//               mispredict_count      - saturating misprediction count
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int ENTRIES   = 16,
    parameter int MODE      = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] lookup_pc,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_pred_taken,
    output logic [15:0]          mispredict_count
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = WORD_SIZE - IDX;

    localparam logic [WORD_SIZE-1:0] c_PC_STEP = 1;

    // Elaboration-time parameter legality check
    generate
        if ((ENTRIES < 2) || (ENTRIES > 256) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
            $error("branch_predictor: ENTRIES must be a power of two in 2..256");
        end
        if ((MODE < 0) || (MODE > 2)) begin : g_bad_mode
            $error("branch_predictor: MODE must be 0, 1 or 2");
        end
        if (WORD_SIZE <= IDX) begin : g_bad_word
            $error("branch_predictor: WORD_SIZE must exceed log2(ENTRIES)");
        end
    endgenerate

    // Table storage
    logic                 r_valid  [ENTRIES];
    logic [TAG-1:0]       r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];
    logic [1:0]           r_ctr    [ENTRIES];
    logic [15:0]          r_mis_cnt;

    // Lookup path
    logic [IDX-1:0] w_lk_idx;
    logic [TAG-1:0] w_lk_tag;
    logic           w_lk_hit;
    logic           w_pred;

    // Update path
    logic [IDX-1:0] w_up_idx;
    logic [TAG-1:0] w_up_tag;
    logic           w_up_hit;

    assign w_lk_idx = lookup_pc[IDX-1:0];
    assign w_lk_tag = lookup_pc[WORD_SIZE-1:IDX];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign w_up_idx = upd_pc[IDX-1:0];
    assign w_up_tag = upd_pc[WORD_SIZE-1:IDX];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Output policy; the table is maintained identically in every mode
    generate
        if (MODE == 0) begin : g_mode_nt
            assign w_pred = 1'b0;
        end else if (MODE == 1) begin : g_mode_hit
            assign w_pred = w_lk_hit;
        end else begin : g_mode_ctr
            assign w_pred = w_lk_hit && r_ctr[w_lk_idx][1];
        end
    endgenerate

    assign pred_taken       = w_pred;
    assign pred_next_pc     = w_pred ? r_target[w_lk_idx] : (lookup_pc + c_PC_STEP);
    assign mispredict_count = r_mis_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'd1;
            end
            r_mis_cnt <= 16'd0;
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    r_target[w_up_idx] <= upd_target;
                    if (r_ctr[w_up_idx] != 2'd3) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                    end
                end else if (r_ctr[w_up_idx] != 2'd0) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate as weakly taken, evicting whatever aliased here
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= upd_target;
                r_ctr[w_up_idx]    <= 2'd2;
            end

            if ((upd_taken != upd_pred_taken) && (r_mis_cnt != 16'hFFFF)) begin
                r_mis_cnt <= r_mis_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//==============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench. Three predictor instances (MODE
//               0, 1 and 2) share one stimulus stream so the output policies
//               can be compared against the same table contents.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        Clk;
    logic        Reset;
    logic [15:0] lookup_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;

    logic        m0_taken, m1_taken, m2_taken;
    logic [15:0] m0_next,  m1_next,  m2_next;
    logic [15:0] m0_cnt,   m1_cnt,   m2_cnt;

    int passed;
    int total;

    branch_predictor #(.WORD_SIZE(16), .ENTRIES(16), .MODE(0)) u_dut_m0 (
        .Clk(Clk), .Reset(Reset), .lookup_pc(lookup_pc),
        .pred_taken(m0_taken), .pred_next_pc(m0_next),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict_count(m0_cnt)
    );

    branch_predictor #(.WORD_SIZE(16), .ENTRIES(16), .MODE(1)) u_dut_m1 (
        .Clk(Clk), .Reset(Reset), .lookup_pc(lookup_pc),
        .pred_taken(m1_taken), .pred_next_pc(m1_next),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict_count(m1_cnt)
    );

    branch_predictor #(.WORD_SIZE(16), .ENTRIES(16), .MODE(2)) u_dut_m2 (
        .Clk(Clk), .Reset(Reset), .lookup_pc(lookup_pc),
        .pred_taken(m2_taken), .pred_next_pc(m2_next),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict_count(m2_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Present one resolved branch for exactly one rising edge
    task automatic drive_update(input logic [15:0] pc, input logic taken,
                                input logic [15:0] target, input logic pred);
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = target;
        upd_pred_taken = pred;
        upd_valid      = 1'b1;
        @(posedge Clk);
        #1;
        upd_valid      = 1'b0;
    endtask

    task automatic test_reset();
        // Reset together with a pending mispredicted taken update
        Reset = 1'b1;
        upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0040;
        upd_pred_taken = 1'b0; upd_valid = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0; upd_valid = 1'b0;
        lookup_pc = 16'h0010; #1;
        total++;
        if (m2_taken !== 1'b0) $display("FAIL reset_pred actual=%0h required=0", m2_taken);
        else passed++;
        total++;
        if (m1_taken !== 1'b0) $display("FAIL reset_pred_m1 actual=%0h required=0", m1_taken);
        else passed++;
        total++;
        if (m2_next !== 16'h0011) $display("FAIL reset_next actual=%0h required=0011", m2_next);
        else passed++;
        total++;
        if (m2_cnt !== 16'h0000) $display("FAIL reset_count actual=%0h required=0000", m2_cnt);
        else passed++;
        lookup_pc = 16'hFFFF; #1;
        total++;
        if (m2_next !== 16'h0000) $display("FAIL reset_wrap actual=%0h required=0000", m2_next);
        else passed++;
    endtask

    task automatic test_allocate();
        drive_update(16'h0010, 1'b1, 16'h0040, 1'b0);
        lookup_pc = 16'h0010; #1;
        total++;
        if (m2_taken !== 1'b1) $display("FAIL alloc_pred_m2 actual=%0h required=1", m2_taken);
        else passed++;
        total++;
        if (m2_next !== 16'h0040) $display("FAIL alloc_next_m2 actual=%0h required=0040", m2_next);
        else passed++;
        total++;
        if (m1_taken !== 1'b1 || m1_next !== 16'h0040)
            $display("FAIL alloc_m1 actual=%0h/%0h required=1/0040", m1_taken, m1_next);
        else passed++;
        total++;
        if (m0_taken !== 1'b0 || m0_next !== 16'h0011)
            $display("FAIL alloc_m0 actual=%0h/%0h required=0/0011", m0_taken, m0_next);
        else passed++;
        total++;
        if (m2_cnt !== 16'd1) $display("FAIL alloc_count actual=%0d required=1", m2_cnt);
        else passed++;
    endtask

    task automatic test_saturation();
        // Entry at 0x0010 sits at ctr=2; walk it down to 0 and back up to 3
        logic        exp_pred [6];
        logic        upd_dir  [6];
        logic [15:0] upd_tgt  [6];
        logic [15:0] exp_next [6];
        upd_dir  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_pred = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        upd_tgt  = '{16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0040, 16'h0044};
        exp_next = '{16'h0011, 16'h0011, 16'h0011, 16'h0011, 16'h0040, 16'h0044};
        lookup_pc = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            // The first step is a mispredicted not-taken branch
            drive_update(16'h0010, upd_dir[i], upd_tgt[i], (i == 0) ? 1'b1 : upd_dir[i]);
            total++;
            if (m2_taken !== exp_pred[i] || m2_next !== exp_next[i])
                $display("FAIL sat_step%0d actual=%0h/%0h required=%0h/%0h",
                         i, m2_taken, m2_next, exp_pred[i], exp_next[i]);
            else passed++;
            total++;
            if (m1_taken !== 1'b1)
                $display("FAIL sat_m1_step%0d actual=%0h required=1", i, m1_taken);
            else passed++;
        end
        total++;
        if (m2_cnt !== 16'd2) $display("FAIL sat_count actual=%0d required=2", m2_cnt);
        else passed++;
    endtask

    task automatic test_alias();
        drive_update(16'h0013, 1'b1, 16'h0100, 1'b1);
        lookup_pc = 16'h0013; #1;
        total++;
        if (m2_taken !== 1'b1 || m2_next !== 16'h0100)
            $display("FAIL alias_first actual=%0h/%0h required=1/0100", m2_taken, m2_next);
        else passed++;
        drive_update(16'h0023, 1'b1, 16'h0200, 1'b0);
        lookup_pc = 16'h0013; #1;
        total++;
        if (m2_taken !== 1'b0 || m2_next !== 16'h0014)
            $display("FAIL alias_evicted actual=%0h/%0h required=0/0014", m2_taken, m2_next);
        else passed++;
        // Not-taken miss at the same index must leave the occupant alone
        drive_update(16'h0033, 1'b0, 16'h0300, 1'b0);
        lookup_pc = 16'h0023; #1;
        total++;
        if (m2_taken !== 1'b1 || m2_next !== 16'h0200)
            $display("FAIL alias_second actual=%0h/%0h required=1/0200", m2_taken, m2_next);
        else passed++;
        total++;
        if (m2_cnt !== 16'd3) $display("FAIL alias_count actual=%0d required=3", m2_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        lookup_pc      = 16'h0050;
        upd_pc         = 16'h0050;
        upd_taken      = 1'b1;
        upd_target     = 16'h0060;
        upd_pred_taken = 1'b0;
        upd_valid      = 1'b1;
        #1;
        total++;
        if (m2_taken !== 1'b0 || m2_next !== 16'h0051)
            $display("FAIL same_cycle_pre actual=%0h/%0h required=0/0051", m2_taken, m2_next);
        else passed++;
        @(posedge Clk); #1;
        upd_valid = 1'b0;
        total++;
        if (m2_taken !== 1'b1 || m2_next !== 16'h0060)
            $display("FAIL same_cycle_post actual=%0h/%0h required=1/0060", m2_taken, m2_next);
        else passed++;
        lookup_pc = 16'hFFFF; #1;
        total++;
        if (m2_taken !== 1'b0 || m2_next !== 16'h0000)
            $display("FAIL wrap_miss actual=%0h/%0h required=0/0000", m2_taken, m2_next);
        else passed++;
        total++;
        if (m2_cnt !== 16'd4 || m0_cnt !== 16'd4)
            $display("FAIL b2b_count actual=%0d/%0d required=4/4", m2_cnt, m0_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        Reset = 1'b1;
        upd_pc = 16'h0050; upd_taken = 1'b0; upd_target = 16'h0000;
        upd_pred_taken = 1'b1; upd_valid = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; upd_valid = 1'b0;
        lookup_pc = 16'h0050; #1;
        total++;
        if (m1_taken !== 1'b0 || m1_next !== 16'h0051)
            $display("FAIL midreset_0050 actual=%0h/%0h required=0/0051", m1_taken, m1_next);
        else passed++;
        lookup_pc = 16'h0023; #1;
        total++;
        if (m1_taken !== 1'b0 || m1_next !== 16'h0024)
            $display("FAIL midreset_0023 actual=%0h/%0h required=0/0024", m1_taken, m1_next);
        else passed++;
        total++;
        if (m2_cnt !== 16'd0 || m1_cnt !== 16'd0)
            $display("FAIL midreset_count actual=%0d/%0d required=0/0", m2_cnt, m1_cnt);
        else passed++;
        // Table must be usable again after the mid-run reset
        drive_update(16'h0023, 1'b1, 16'h0777, 1'b1);
        total++;
        if (m2_taken !== 1'b1 || m2_next !== 16'h0777 || m2_cnt !== 16'd0)
            $display("FAIL midreset_realloc actual=%0h/%0h/%0d required=1/0777/0",
                     m2_taken, m2_next, m2_cnt);
        else passed++;
    endtask

    initial begin
        passed         = 0;
        total          = 0;
        Reset          = 1'b0;
        lookup_pc      = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_pred_taken = 1'b0;

        test_reset();
        test_allocate();
        test_saturation();
        test_alias();
        test_back_to_back();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
